// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences the datapath one instruction at a time.
// Ports: clk, rst (async, active-high); opc/func decode fields; mem_ready
//   data-memory ack; datapath controls (RegDest..Branch, operation);
//   pc_write/ir_write enables; illegal_op/mem_error pulses; retired count.
module multicycle_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opc,
    input  logic [5:0]       func,
    input  logic             mem_ready,
    output logic             RegDest,
    output logic             RegisterWrite,
    output logic             ALUSource,
    output logic             WriteMem,
    output logic             ReadMem,
    output logic             MemToReg,
    output logic             ALUSource2,
    output logic             RegSel,
    output logic             Branch,
    output logic [3:0]       operation,
    output logic             pc_write,
    output logic             ir_write,
    output logic             illegal_op,
    output logic             mem_error,
    output logic [CNT_W-1:0] retired
);

    localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t           r_state;
    logic [5:0]       r_opc;
    logic [5:0]       r_func;
    logic [WW-1:0]    r_wait;
    logic [CNT_W-1:0] r_retired;

    logic       w_rtype;
    logic       w_r_ok;
    logic       w_sll;
    logic       w_addi;
    logic       w_lw;
    logic       w_sw;
    logic       w_bne;
    logic       w_legal;
    logic       w_timeout;
    logic       w_alu_phase;
    logic [3:0] w_op;

    // Decode works only on the latched fields, so outputs never see opc/func
    assign w_rtype = (r_opc == 6'h00);
    assign w_sll   = w_rtype && (r_func == 6'h00);
    assign w_addi  = (r_opc == 6'h08);
    assign w_lw    = (r_opc == 6'h23);
    assign w_sw    = (r_opc == 6'h2B);
    assign w_bne   = (r_opc == 6'h05);
    assign w_legal = w_r_ok || w_addi || w_lw || w_sw || w_bne;

    assign w_timeout   = (r_wait == WW'(MEM_TIMEOUT));
    assign w_alu_phase = (r_state == S_EXEC) || (r_state == S_MEM)
                      || (r_state == S_WB);

    always_comb begin
        w_r_ok = 1'b0;
        w_op   = 4'b0010;
        if (w_rtype) begin
            w_r_ok = 1'b1;
            case (r_func)
                6'h20:   w_op = 4'b0010;
                6'h22:   w_op = 4'b0110;
                6'h24:   w_op = 4'b0000;
                6'h25:   w_op = 4'b0001;
                6'h2A:   w_op = 4'b0111;
                6'h00:   w_op = 4'b0011;
                default: w_r_ok = 1'b0;
            endcase
        end else if (w_bne) begin
            w_op = 4'b0110;
        end
    end

    // Fields are captured as DECODE is entered so that the DECODE
    // cycle can already flag an illegal instruction from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_opc     <= 6'h00;
            r_func    <= 6'h00;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    r_opc   <= opc;
                    r_func  <= func;
                    r_state <= S_DECODE;
                end
                S_DECODE: r_state <= w_legal ? S_EXEC : S_FETCH;
                S_EXEC: begin
                    if (w_bne) begin
                        r_retired <= r_retired + 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_lw || w_sw) begin
                        r_wait  <= '0;
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    // Timeout takes priority over a late ack
                    if (w_timeout) begin
                        r_state <= S_FETCH;
                    end else if (mem_ready) begin
                        if (w_sw) begin
                            r_retired <= r_retired + 1'b1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_WB: begin
                    r_retired <= r_retired + 1'b1;
                    r_state   <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        RegDest       = 1'b0;
        RegisterWrite = 1'b0;
        ALUSource     = 1'b0;
        WriteMem      = 1'b0;
        ReadMem       = 1'b0;
        MemToReg      = 1'b0;
        ALUSource2    = 1'b0;
        RegSel        = 1'b0;
        Branch        = 1'b0;
        operation     = 4'b0000;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        illegal_op    = 1'b0;
        mem_error     = 1'b0;
        if (w_alu_phase) begin
            ALUSource  = w_addi || w_lw || w_sw;
            ALUSource2 = w_sll;
            RegSel     = w_sll;
            operation  = w_op;
        end
        case (r_state)
            S_FETCH: ir_write = 1'b1;
            S_DECODE: begin
                illegal_op = !w_legal;
                pc_write   = !w_legal;
            end
            S_EXEC: begin
                Branch   = w_bne;
                pc_write = w_bne;
            end
            S_MEM: begin
                // Strobes drop on the abort cycle
                ReadMem   = w_lw && !w_timeout;
                MemToReg  = w_lw && !w_timeout;
                WriteMem  = w_sw && !w_timeout;
                mem_error = w_timeout;
                pc_write  = w_timeout || (w_sw && mem_ready);
            end
            S_WB: begin
                RegisterWrite = 1'b1;
                pc_write      = 1'b1;
                RegDest       = w_rtype;
                MemToReg      = w_lw;
            end
            default: ;
        endcase
    end

    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases then
// random instructions against a per-instruction cycle-sequence model.
module tb_multicycle_controller;

    localparam int CW = 4;
    localparam int TO = 15;

    localparam logic [16:0] RD   = 17'h10000;
    localparam logic [16:0] RW   = 17'h08000;
    localparam logic [16:0] AS   = 17'h04000;
    localparam logic [16:0] WM   = 17'h02000;
    localparam logic [16:0] RM   = 17'h01000;
    localparam logic [16:0] MTR  = 17'h00800;
    localparam logic [16:0] AS2  = 17'h00400;
    localparam logic [16:0] RS   = 17'h00200;
    localparam logic [16:0] BR   = 17'h00100;
    localparam logic [16:0] PCW  = 17'h00008;
    localparam logic [16:0] IRW  = 17'h00004;
    localparam logic [16:0] ILL  = 17'h00002;
    localparam logic [16:0] MERR = 17'h00001;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opc;
    logic [5:0]    func;
    logic          mem_ready;
    logic          RegDest, RegisterWrite, ALUSource, WriteMem, ReadMem;
    logic          MemToReg, ALUSource2, RegSel, Branch;
    logic [3:0]    operation;
    logic          pc_write, ir_write, illegal_op, mem_error;
    logic [CW-1:0] retired;
    logic [16:0]   obs;

    int ncmp  = 0;
    int nfail = 0;
    int mret  = 0;

    multicycle_controller #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opc(opc), .func(func),
        .mem_ready(mem_ready),
        .RegDest(RegDest), .RegisterWrite(RegisterWrite),
        .ALUSource(ALUSource), .WriteMem(WriteMem), .ReadMem(ReadMem),
        .MemToReg(MemToReg), .ALUSource2(ALUSource2), .RegSel(RegSel),
        .Branch(Branch), .operation(operation), .pc_write(pc_write),
        .ir_write(ir_write), .illegal_op(illegal_op),
        .mem_error(mem_error), .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs = {RegDest, RegisterWrite, ALUSource, WriteMem, ReadMem,
                  MemToReg, ALUSource2, RegSel, Branch, operation,
                  pc_write, ir_write, illegal_op, mem_error};

    // 0 R-alu, 1 SLL, 2 addi, 3 lw, 4 sw, 5 bne, 6 illegal
    function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            case (f)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return 0;
                6'h00: return 1;
                default: return 6;
            endcase
        end
        case (o)
            6'h08: return 2;
            6'h23: return 3;
            6'h2B: return 4;
            6'h05: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic logic [16:0] alu_of(input int c, input logic [5:0] f);
        logic [3:0] op;
        op = 4'b0000;
        case (c)
            0: begin
                case (f)
                    6'h20: op = 4'b0010;
                    6'h22: op = 4'b0110;
                    6'h24: op = 4'b0000;
                    6'h25: op = 4'b0001;
                    default: op = 4'b0111;
                endcase
                return 17'(op) << 4;
            end
            1: return AS2 | RS | (17'(4'b0011) << 4);
            2, 3, 4: return AS | (17'(4'b0010) << 4);
            5: return 17'(4'b0110) << 4;
            default: return 17'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        ncmp++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic rdy, input logic [16:0] ev,
                        input bit ret, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        chk({tag, "_out"}, 32'(obs), 32'(ev));
        chk({tag, "_ret"}, 32'(retired), 32'(mret % (1 << CW)));
        @(posedge clk);
        #1;
        if (ret) mret = (mret + 1) % (1 << CW);
    endtask

    // delay: number of MEMORY cycles with mem_ready low before it rises
    task automatic run(input logic [5:0] o, input logic [5:0] f,
                       input int delay, input bit abort_wb);
        int c;
        logic [16:0] a;
        logic r;
        c = cls_of(o, f);
        a = alu_of(c, f);
        opc  = o;
        func = f;
        step(rnd(), IRW, 0, "fetch");
        if (c == 6) begin
            step(rnd(), ILL | PCW, 0, "decode_ill");
            return;
        end
        step(rnd(), 17'h0, 0, "decode");
        if (c == 5) begin
            step(rnd(), a | BR | PCW, 1, "exec_bne");
            return;
        end
        step(rnd(), a, 0, "exec");
        if (c == 3 || c == 4) begin
            for (int k = 0; k <= TO; k++) begin
                if (k == TO) begin
                    step(rnd(), a | MERR | PCW, 0, "mem_timeout");
                    return;
                end
                r = (k >= delay);
                if (c == 4) begin
                    step(r, a | WM | (r ? PCW : 17'h0), r, "mem_sw");
                    if (r) return;
                end else begin
                    step(r, a | RM | MTR, 0, "mem_lw");
                    if (r) break;
                end
            end
        end
        a = a | RW | PCW | ((c <= 1) ? RD : 17'h0) | ((c == 3) ? MTR : 17'h0);
        if (!abort_wb) begin
            step(rnd(), a, 1, "wb");
            return;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("wb_pre_rst", 32'(obs), 32'(a));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(obs), 32'h0);
        chk("async_rst_ret", 32'(retired), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_out", 32'(obs), 32'h0);
        rst  = 1'b0;
        mret = 0;
        step(rnd(), 17'h0, 0, "idle_after_rst");
    endtask

    logic [5:0] rfun [6];
    int sel;

    initial begin
        rfun[0] = 6'h20; rfun[1] = 6'h22; rfun[2] = 6'h24;
        rfun[3] = 6'h25; rfun[4] = 6'h2A; rfun[5] = 6'h00;
        rst = 1'b1;
        opc = 6'h00;
        func = 6'h20;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(obs), 32'h0);
        chk("reset_ret", 32'(retired), 32'h0);
        rst = 1'b0;
        step(rnd(), 17'h0, 0, "idle");

        run(6'h00, 6'h20, 0, 0);
        run(6'h23, 6'h00, 3, 0);
        run(6'h2B, 6'h00, TO + 5, 0);
        run(6'h05, 6'h00, 0, 0);
        run(6'h3F, 6'h00, 0, 0);
        run(6'h00, 6'h21, 0, 0);
        run(6'h2B, 6'h00, 0, 0);
        run(6'h23, 6'h00, TO - 1, 0);
        run(6'h00, 6'h00, 0, 1);

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1, 2, 3, 4, 5: run(6'h00, rfun[sel], 0, 0);
                6: run(6'h08, 6'($urandom), 0, 0);
                7: run(6'h23, 6'($urandom), $urandom_range(0, TO + 1), 0);
                8: run(6'h2B, 6'($urandom), $urandom_range(0, TO + 1), 0);
                9: run(6'h05, 6'($urandom), 0, 0);
                default: run(6'($urandom), 6'($urandom),
                             $urandom_range(0, TO + 1), 0);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM that sequences the existing datapath one instruction at a time.
- Decodes opc/func from the datapath and drives its control inputs (RegDest … Branch, operation), plus PC and IR write enables.
- Holds in the MEMORY state while data memory is not ready, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 15, max MEMORY-state wait cycles before error abort (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opc  in  6  instruction opcode field [31:26]
func  in  6  instruction function field [5:0]
mem_ready  in  1  data memory ready/ack; sampled in MEMORY state
RegDest, RegisterWrite, ALUSource, WriteMem, ReadMem, MemToReg, ALUSource2, RegSel, Branch  out  1 each  datapath controls
operation  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0011 SLL
pc_write  out  1  PC update enable
ir_write  out  1  instruction register load enable
illegal_op  out  1  one-cycle pulse on unsupported opcode/func
mem_error  out  1  one-cycle pulse on memory timeout abort
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset: asynchronous, active-high. State = S_IDLE. retired = 0, wait counter = 0. All outputs 0 while rst is high and in S_IDLE.
- Outputs are Moore: decoded from the state register and latched decode registers. No combinational path from opc/func to outputs.
- States and transitions:
  - S_IDLE: always → FETCH.
  - FETCH: ir_write = 1. → DECODE.
  - DECODE: latch opc/func into internal registers.
    - Unsupported code: pulse illegal_op and pc_write (skip instruction) → FETCH. retired not incremented.
    - Otherwise → EXECUTE.
  - EXECUTE:
    - R-type (opc 000000): func 20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT → ALUSource = 0, RegSel = 0. func 00 SLL → ALUSource2 = 1, RegSel = 1. → WRITEBACK.
    - addi (08), lw (23), sw (2B): ALUSource = 1, operation = ADD. addi → WRITEBACK; lw/sw → MEMORY.
    - bne (05): operation = SUB, Branch = 1, pc_write = 1, retired++. → FETCH.
  - MEMORY: address/ALU controls held stable. lw: ReadMem = 1, MemToReg = 1. sw: WriteMem = 1.
    - mem_ready = 1: sw → pc_write = 1, retired++, → FETCH. lw → WRITEBACK.
    - mem_ready = 0: stay; wait counter++.
    - Wait counter reaches MEM_TIMEOUT: pulse mem_error, WriteMem/ReadMem drop, pc_write = 1, → FETCH, no retire.
    - Wait counter clears on MEMORY entry.
  - WRITEBACK: RegisterWrite = 1, pc_write = 1, retired++. → FETCH.
    - RegDest = 1 for R-type, 0 for addi/lw. MemToReg = 1 only for lw.
    - ALU controls held from EXECUTE.
- Cycle counts: R-type/addi 4, sw 4 + waits, lw 5 + waits, bne 3, illegal 2.
- Exclusivity:
  - RegisterWrite never asserts outside WRITEBACK; WriteMem never asserts outside MEMORY.
  - WriteMem and ReadMem are never both 1.
  - pc_write asserts exactly once per instruction.
- retired wraps modulo 2^CNT_W.
- Reset mid-operation: immediate return to S_IDLE with all outputs 0, including mid-MEMORY with WriteMem high. retired clears.
- mem_ready outside MEMORY is ignored.

Test Plan:
- Reset then opc = 00, func = 20 held → cycle 1 IDLE all-zero; FETCH ir_write = 1; EXECUTE operation = 0010; WRITEBACK RegisterWrite = 1, RegDest = 1, pc_write = 1; retired = 1.
- lw (opc 23), mem_ready low 3 cycles then high → ReadMem = 1 for 4 MEMORY cycles; WRITEBACK MemToReg = 1, RegDest = 0; total 8 cycles; retired++.
- sw (opc 2B), mem_ready never high, MEM_TIMEOUT = 15 → WriteMem high 15 cycles; mem_error pulses once; FETCH follows; retired unchanged; RegisterWrite never 1.
- bne (opc 05) → EXECUTE Branch = 1, operation = 0110, pc_write = 1; next cycle FETCH; 3 cycles total.
- opc = 3F → DECODE pulses illegal_op and pc_write; no RegisterWrite/WriteMem; retired unchanged.
- SLL (func 00) → ALUSource2 = 1, RegSel = 1, operation = 0011. Assert rst during its WRITEBACK → all outputs 0 asynchronously; retired = 0.
